// File: rtl/decoder_scan_seq_if.sv
// rtl/decoder_scan_seq_if.sv - scan request inputs and decoder drive outputs
interface decoder_scan_seq_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic               cont;
   logic [7:0]         mask;
   logic [DWELL_W-1:0] dwell;
   logic               A;
   logic               B;
   logic               C;
   logic               en;
   logic               ch_strobe;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, cont, mask, dwell,
      input  A, B, C, en, ch_strobe, busy, done
   );

   modport slave (
      input  start, stop, cont, mask, dwell,
      output A, B, C, en, ch_strobe, busy, done
   );
endinterface

// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - walks the enabled channels of a 3-to-8 decoder
// with a programmable dwell per channel, single pass or continuous.
module decoder_scan_seq #(
   parameter int DWELL_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   decoder_scan_seq_if.slave   io_bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t             r_state,  w_state_nx;
   logic [7:0]         r_mask,   w_mask_nx;
   logic [DWELL_W-1:0] r_dwell,  w_dwell_nx;
   logic [DWELL_W-1:0] r_cnt,    w_cnt_nx;
   logic               r_cont,   w_cont_nx;
   logic [2:0]         r_ch,     w_ch_nx;
   logic               r_en,     w_en_nx;
   logic               r_strobe, w_strobe_nx;
   logic               r_busy,   w_busy_nx;
   logic               r_done,   w_done_nx;

   logic [3:0]         w_first;
   logic [3:0]         w_hi;
   logic [3:0]         w_lo;

   // {found, index} of the lowest set bit of m; when any=0 only bits above cur count
   function automatic logic [3:0] f_pick(input logic [7:0] m, input logic [2:0] cur,
                                         input logic any);
      logic [3:0] v;
      v = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (any || (i > int'(cur))))
            v = {1'b1, 3'(i)};
      end
      return v;
   endfunction

   assign w_first = f_pick(io_bus.mask, 3'd0, 1'b1);
   assign w_hi    = f_pick(r_mask, r_ch, 1'b0);
   assign w_lo    = f_pick(r_mask, 3'd0, 1'b1);

   always_comb begin
      w_state_nx  = r_state;
      w_mask_nx   = r_mask;
      w_dwell_nx  = r_dwell;
      w_cont_nx   = r_cont;
      w_cnt_nx    = r_cnt;
      w_ch_nx     = r_ch;
      w_en_nx     = 1'b0;
      w_strobe_nx = 1'b0;
      w_busy_nx   = 1'b0;
      w_done_nx   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start && !io_bus.stop) begin
               if (w_first[3]) begin
                  w_mask_nx   = io_bus.mask;
                  w_dwell_nx  = io_bus.dwell;
                  w_cont_nx   = io_bus.cont;
                  w_cnt_nx    = '0;
                  w_ch_nx     = w_first[2:0];
                  w_state_nx  = S_ACTIVE;
                  w_en_nx     = 1'b1;
                  w_busy_nx   = 1'b1;
                  w_strobe_nx = 1'b1;
               end else begin
                  w_done_nx   = 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (io_bus.stop) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt == r_dwell) begin
               // window ends: next higher channel, else wrap or finish
               if (w_hi[3] || (r_cont && w_lo[3])) begin
                  w_ch_nx     = w_hi[3] ? w_hi[2:0] : w_lo[2:0];
                  w_cnt_nx    = '0;
                  w_en_nx     = 1'b1;
                  w_busy_nx   = 1'b1;
                  w_strobe_nx = 1'b1;
               end else begin
                  w_state_nx  = S_DONE;
                  w_done_nx   = 1'b1;
               end
            end else begin
               w_cnt_nx  = r_cnt + 1'b1;
               w_en_nx   = 1'b1;
               w_busy_nx = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_mask   <= 8'd0;
         r_dwell  <= '0;
         r_cont   <= 1'b0;
         r_cnt    <= '0;
         r_ch     <= 3'd0;
         r_en     <= 1'b0;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_mask   <= w_mask_nx;
         r_dwell  <= w_dwell_nx;
         r_cont   <= w_cont_nx;
         r_cnt    <= w_cnt_nx;
         r_ch     <= w_ch_nx;
         r_en     <= w_en_nx;
         r_strobe <= w_strobe_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
      end
   end

   assign io_bus.A         = r_ch[2];
   assign io_bus.B         = r_ch[1];
   assign io_bus.C         = r_ch[0];
   assign io_bus.en        = r_en;
   assign io_bus.ch_strobe = r_strobe;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb/tb_decoder_scan_seq.sv - randomized and directed checks of decoder_scan_seq
module tb_decoder_scan_seq;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   decoder_scan_seq_if #(.DWELL_W(8)) bus ();

   decoder_scan_seq #(.DWELL_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a pass is flattened into a list of per-cycle (channel, strobe) entries
   typedef struct {
      logic [2:0] ch;
      logic       stb;
   } ent_t;

   ent_t       q[$];
   logic       m_active, m_in_done, m_cont;
   logic [7:0] m_mask, m_dwell;
   logic [2:0] exp_ch;
   logic       exp_en, exp_stb, exp_done;

   task automatic push_lap();
      ent_t e;
      for (int i = 0; i < 8; i++) begin
         if (m_mask[i]) begin
            for (int k = 0; k <= int'(m_dwell); k++) begin
               e.ch  = 3'(i);
               e.stb = (k == 0);
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic pop_entry();
      ent_t e;
      e = q.pop_front();
      exp_ch  = e.ch;
      exp_stb = e.stb;
      exp_en  = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_active = 0; m_in_done = 0; m_cont = 0; m_mask = 0; m_dwell = 0;
         exp_ch = 0; exp_en = 0; exp_stb = 0; exp_done = 0;
      end else begin
         exp_done = 0;
         exp_stb  = 0;
         if (m_active) begin
            if (bus.stop) begin
               m_active = 0;
               q.delete();
               exp_en = 0;
            end else begin
               if (q.size() == 0 && m_cont) push_lap();
               if (q.size() == 0) begin
                  m_active  = 0;
                  m_in_done = 1;
                  exp_en    = 0;
                  exp_done  = 1;
               end else begin
                  pop_entry();
               end
            end
         end else if (m_in_done) begin
            m_in_done = 0;
         end else if (bus.start && !bus.stop) begin
            if (bus.mask == 0) begin
               exp_done = 1;
            end else begin
               m_mask   = bus.mask;
               m_dwell  = bus.dwell;
               m_cont   = bus.cont;
               m_active = 1;
               push_lap();
               pop_entry();
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("cycle", {25'd0, bus.A, bus.B, bus.C, bus.en, bus.ch_strobe, bus.busy, bus.done},
          {25'd0, exp_ch, exp_en, exp_stb, exp_en, exp_done});
   end

   task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, input logic c);
      bus.mask  = m;
      bus.dwell = d;
      bus.cont  = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   function automatic logic [2:0] abc();
      return {bus.A, bus.B, bus.C};
   endfunction

   initial begin
      logic [2:0] chs[4];
      chs = '{3'd0, 3'd2, 3'd5, 3'd7};
      rst_n = 1'b0;
      bus.start = 0; bus.stop = 0; bus.cont = 0; bus.mask = 0; bus.dwell = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {25'd0, abc(), bus.en, bus.ch_strobe, bus.busy, bus.done}, 32'd0);

      // full single pass, start accepted on first edge after reset release
      rst_n = 1'b1;
      pulse_start(8'hFF, 8'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("ff_ch", abc(), i);
         chk("ff_strobe", bus.ch_strobe, 1);
         chk("ff_en", bus.en, 1);
         @(negedge clk);
      end
      chk("ff_done", bus.done, 1);
      chk("ff_done_en", bus.en, 0);
      @(negedge clk);
      chk("ff_busy_after", bus.busy, 0);

      // sparse mask, dwell 2
      pulse_start(8'hA5, 8'd2, 1'b0);
      for (int c = 0; c < 12; c++) begin
         chk("a5_ch", abc(), chs[c/3]);
         chk("a5_strobe", bus.ch_strobe, (c % 3 == 0));
         chk("a5_en", bus.en, 1);
         @(negedge clk);
      end
      chk("a5_done", bus.done, 1);
      @(negedge clk);

      // empty mask
      pulse_start(8'h00, 8'd0, 1'b0);
      chk("empty_done", bus.done, 1);
      chk("empty_en", {bus.en, bus.busy}, 0);
      @(negedge clk);
      chk("empty_done_once", bus.done, 0);

      // start and stop together in idle
      bus.mask = 8'hFF; bus.start = 1; bus.stop = 1;
      @(negedge clk);
      bus.start = 0; bus.stop = 0;
      chk("startstop_idle", {bus.en, bus.busy, bus.done}, 0);

      // continuous wrap then stop
      pulse_start(8'h81, 8'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         chk("wrap_ch", abc(), (i % 2) ? 7 : 0);
         chk("wrap_strobe", bus.ch_strobe, 1);
         @(negedge clk);
      end
      bus.stop = 1;
      @(negedge clk);
      bus.stop = 0;
      chk("stop_outputs", {bus.en, bus.busy, bus.done}, 0);
      @(negedge clk);
      chk("stop_no_done", bus.done, 0);

      // start mid-scan is ignored
      pulse_start(8'h0F, 8'd1, 1'b0);
      @(negedge clk);
      bus.mask = 8'h80; bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      chk("midscan_ch", abc(), 1);
      chk("midscan_strobe", bus.ch_strobe, 1);
      repeat (8) @(negedge clk);

      // all-ones dwell: one window of 256 cycles
      pulse_start(8'h08, 8'hFF, 1'b0);
      chk("long_first", {abc(), bus.ch_strobe}, {3'd3, 1'b1});
      repeat (255) @(negedge clk);
      chk("long_last", {bus.en, bus.ch_strobe}, 2'b10);
      @(negedge clk);
      chk("long_done", bus.done, 1);
      @(negedge clk);

      // asynchronous reset during channel 5
      pulse_start(8'h24, 8'd3, 1'b0);
      repeat (5) @(negedge clk);
      chk("pre_reset_ch", abc(), 5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {abc(), bus.en, bus.busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start(8'h30, 8'd0, 1'b0);
      chk("after_reset_ch", {abc(), bus.en}, {3'd4, 1'b1});
      repeat (3) @(negedge clk);

      // randomized traffic, inputs changing every cycle
      repeat (3000) begin
         bus.start = ($urandom % 6) == 0;
         bus.stop  = ($urandom % 25) == 0;
         bus.cont  = $urandom % 2;
         case ($urandom % 4)
            0: bus.mask = 8'h00;
            1: bus.mask = 8'(1 << ($urandom % 8));
            default: bus.mask = 8'($urandom);
         endcase
         bus.dwell = (($urandom % 10) == 0) ? 8'd15 : 8'($urandom % 4);
         @(negedge clk);
      end
      bus.start = 0; bus.stop = 1;
      @(negedge clk);
      bus.stop = 0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
